// File: rtl/mmio_timer_responder_pkg.sv
// Shared constants for the memory-mapped timer / LED / digit responder.
// Register offsets are byte offsets inside the peripheral window.
package mmio_timer_responder_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

    localparam logic [7:0] OFF_TH      = 8'h00;
    localparam logic [7:0] OFF_TL      = 8'h04;
    localparam logic [7:0] OFF_TCON    = 8'h08;
    localparam logic [7:0] OFF_LED     = 8'h0C;
    localparam logic [7:0] OFF_DIGI    = 8'h10;
    localparam logic [7:0] OFF_SYSTICK = 8'h14;

    localparam int TCON_EN   = 0;
    localparam int TCON_IE   = 1;
    localparam int TCON_IS   = 2;
    localparam int TCON_BITS = 3;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_TH,
        SEL_TL,
        SEL_TCON,
        SEL_LED,
        SEL_DIGI,
        SEL_SYSTICK
    } reg_sel_e;

endpackage

// File: rtl/mmio_timer_responder_if.sv
// Processor memory-port signals as seen by a memory-mapped responder.
// The processor side is the master; the responder answers with read data and hit.
interface mmio_timer_responder_if;

    logic [31:0] Address;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [31:0] Mem_data;
    logic        hit;

    modport master (
        output Address, MemRead, MemWrite, Write_data,
        input  Mem_data, hit
    );

    modport slave (
        input  Address, MemRead, MemWrite, Write_data,
        output Mem_data, hit
    );

endinterface

// File: rtl/mmio_timer_responder_reload_timer.sv
// Reloading 32-bit timer: TH holds the reload value, TL counts up while
// enabled and reloads from TH after reaching all-ones. TCON carries enable,
// interrupt enable and sticky interrupt status. A bus write always beats the
// timer's own update of the same register, so software never loses a race.
module reload_timer
    import mmio_timer_responder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_th,
    input  logic        wr_tl,
    input  logic        wr_tcon,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [31:0] tcon,
    output logic        irq
);

    logic [31:0]          th_q;
    logic [31:0]          tl_q;
    logic [TCON_BITS-1:0] tcon_q;
    logic                 overflow;

    assign overflow = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);

    // Reload value only changes by a bus write; a reload in the same edge still sees the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            th_q <= '0;
        end else if (wr_th) begin
            th_q <= wdata;
        end
    end

    // Counter: bus write wins, otherwise count or reload when enabled, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            tl_q <= '0;
        end else if (wr_tl) begin
            tl_q <= wdata;
        end else if (tcon_q[TCON_EN]) begin
            tl_q <= overflow ? th_q : tl_q + 32'd1;
        end
    end

    // Control/status: a bus write replaces all bits, otherwise an overflow sets sticky status.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcon_q <= '0;
        end else if (wr_tcon) begin
            tcon_q <= wdata[TCON_BITS-1:0];
        end else if (overflow && tcon_q[TCON_IE]) begin
            tcon_q[TCON_IS] <= 1'b1;
        end
    end

    assign th   = th_q;
    assign tl   = tl_q;
    assign tcon = 32'(tcon_q);
    assign irq  = tcon_q[TCON_IE] & tcon_q[TCON_IS];

endmodule

// File: rtl/mmio_timer_responder.sv
// Memory-mapped peripheral responder: reloading timer, LED register, seven-segment
// digit register and a free-running systick counter. Reads are combinational so
// the processor sees data in the same cycle as the address, exactly like memory.
module mmio_timer_responder
    import mmio_timer_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WINDOW_BITS = 8,
    parameter int          LED_W       = 8,
    parameter int          DIGI_W      = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    mmio_timer_responder_if.slave bus,
    output logic                  irq,
    output logic [LED_W-1:0]      leds,
    output logic [DIGI_W-1:0]     digi
);

    logic [WINDOW_BITS-1:0] offset;
    reg_sel_e               sel;
    logic                   wr_en;
    logic [31:0]            th;
    logic [31:0]            tl;
    logic [31:0]            tcon;
    logic [31:0]            systick;
    logic [LED_W-1:0]       led_q;
    logic [DIGI_W-1:0]      digi_q;
    logic [31:0]            rdata;

    assign bus.hit = (bus.Address[31:WINDOW_BITS] == BASE_ADDR[31:WINDOW_BITS]);
    assign offset  = bus.Address[WINDOW_BITS-1:0] & ~WINDOW_BITS'(3);
    assign wr_en   = bus.hit && bus.MemWrite;

    // Map the word offset inside the window onto a register select.
    always_comb begin
        sel = SEL_NONE;
        case (offset)
            WINDOW_BITS'(OFF_TH):      sel = SEL_TH;
            WINDOW_BITS'(OFF_TL):      sel = SEL_TL;
            WINDOW_BITS'(OFF_TCON):    sel = SEL_TCON;
            WINDOW_BITS'(OFF_LED):     sel = SEL_LED;
            WINDOW_BITS'(OFF_DIGI):    sel = SEL_DIGI;
            WINDOW_BITS'(OFF_SYSTICK): sel = SEL_SYSTICK;
            default:                   sel = SEL_NONE;
        endcase
    end

    reload_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_th   (wr_en && (sel == SEL_TH)),
        .wr_tl   (wr_en && (sel == SEL_TL)),
        .wr_tcon (wr_en && (sel == SEL_TCON)),
        .wdata   (bus.Write_data),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irq     (irq)
    );

    // LED and digit registers take bus writes; systick free-runs and ignores writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q   <= '0;
            digi_q  <= '0;
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
            if (wr_en && (sel == SEL_LED)) begin
                led_q <= bus.Write_data[LED_W-1:0];
            end
            if (wr_en && (sel == SEL_DIGI)) begin
                digi_q <= bus.Write_data[DIGI_W-1:0];
            end
        end
    end

    // Read mux shows pre-write register values, zero-extending the narrow ones.
    always_comb begin
        rdata = '0;
        case (sel)
            SEL_TH:      rdata = th;
            SEL_TL:      rdata = tl;
            SEL_TCON:    rdata = tcon;
            SEL_LED:     rdata = 32'(led_q);
            SEL_DIGI:    rdata = 32'(digi_q);
            SEL_SYSTICK: rdata = systick;
            default:     rdata = '0;
        endcase
    end

    assign bus.Mem_data = (bus.hit && bus.MemRead) ? rdata : 32'h0;
    assign leds         = led_q;
    assign digi         = digi_q;

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Bench for the memory-mapped timer responder. Stimulus pushes the expected
// outputs for each cycle into a scoreboard queue; a monitor on the falling edge
// pops and compares. Expectations come from a register-level reference model.
module tb_mmio_timer_responder;

    localparam logic [31:0] BASE = 32'h4000_0000;

    typedef struct {
        logic [31:0] data;
        logic        hit;
        logic        irq;
        logic [7:0]  leds;
        logic [11:0] digi;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        irq;
    logic [7:0]  leds;
    logic [11:0] digi;
    logic        sb_strobe;
    exp_t        sb_q[$];
    int          n_checks;
    int          n_fail;

    logic [31:0] m_th, m_tl, m_systick;
    logic        m_en, m_ie, m_is;
    logic [7:0]  m_leds;
    logic [11:0] m_digi;

    mmio_timer_responder_if bus ();

    mmio_timer_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq),
        .leds  (leds),
        .digi  (digi)
    );

    always #5 clk = ~clk;

    function automatic logic in_window(input logic [31:0] a);
        return a[31:8] == BASE[31:8];
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [7:0] off;
        if (!in_window(a)) return 32'h0;
        off = {a[7:2], 2'b00};
        case (off)
            8'h00:   return m_th;
            8'h04:   return m_tl;
            8'h08:   return {29'h0, m_is, m_ie, m_en};
            8'h0C:   return {24'h0, m_leds};
            8'h10:   return {20'h0, m_digi};
            8'h14:   return m_systick;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_step(input logic r, input logic [31:0] a,
                                       input logic wr, input logic [31:0] wd);
        logic       ovf;
        logic [7:0] off;
        if (r) begin
            m_th = 0; m_tl = 0; m_systick = 0;
            m_en = 0; m_ie = 0; m_is = 0;
            m_leds = 0; m_digi = 0;
            return;
        end
        ovf = m_en && (m_tl == 32'hFFFF_FFFF);
        if (m_en) m_tl = ovf ? m_th : m_tl + 32'd1;
        if (ovf && m_ie) m_is = 1'b1;
        m_systick = m_systick + 32'd1;
        if (wr && in_window(a)) begin
            off = {a[7:2], 2'b00};
            case (off)
                8'h00: m_th = wd;
                8'h04: m_tl = wd;
                8'h08: {m_is, m_ie, m_en} = wd[2:0];
                8'h0C: m_leds = wd[7:0];
                8'h10: m_digi = wd[11:0];
                default: ;
            endcase
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [31:0] a, input logic rd,
                                 input logic wr, input logic [31:0] wd);
        exp_t e;
        reset          = r;
        bus.Address    = a;
        bus.MemRead    = rd;
        bus.MemWrite   = wr;
        bus.Write_data = wd;
        e.data = rd ? model_read(a) : 32'h0;
        e.hit  = in_window(a);
        e.irq  = m_ie & m_is;
        e.leds = m_leds;
        e.digi = m_digi;
        sb_q.push_back(e);
        sb_strobe = 1'b1;
        @(posedge clk);
        model_step(r, a, wr, wd);
        #1;
    endtask

    task automatic wr_reg(input logic [7:0] off, input logic [31:0] d);
        applyStimulus(1'b0, BASE + 32'(off), 1'b0, 1'b1, d);
    endtask

    task automatic rd_reg(input logic [7:0] off);
        applyStimulus(1'b0, BASE + 32'(off), 1'b1, 1'b0, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic read_all();
        for (int i = 0; i < 6; i++) rd_reg(8'(i * 4));
    endtask

    // Monitor: every strobed cycle, compare all DUT outputs against the queued expectation.
    always @(negedge clk) begin
        if (sb_strobe) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL scoreboard: got empty queue, expected an entry at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("Mem_data", bus.Mem_data, e.data);
                checkOutput("hit", 32'(bus.hit), 32'(e.hit));
                checkOutput("irq", 32'(irq), 32'(e.irq));
                checkOutput("leds", 32'(leds), 32'(e.leds));
                checkOutput("digi", 32'(digi), 32'(e.digi));
            end
        end
    end

    initial begin
        logic [31:0] a, wd;
        logic        rd, wr, r;
        int          sel, waited;

        clk = 0; n_checks = 0; n_fail = 0; sb_strobe = 0;
        reset = 1'b1;
        bus.Address = 0; bus.MemRead = 0; bus.MemWrite = 0; bus.Write_data = 0;
        repeat (2) @(posedge clk);
        model_step(1'b1, 32'h0, 1'b0, 32'h0);
        #1;

        $display("[TB] reset state");
        read_all();

        $display("[TB] reset mid-count");
        wr_reg(8'h0C, 32'h0000_005A);
        wr_reg(8'h10, 32'h0000_0123);
        wr_reg(8'h04, 32'h5);
        wr_reg(8'h08, 32'h7);
        idle(3);
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        read_all();

        $display("[TB] reload and interrupt");
        wr_reg(8'h00, 32'hFFFF_FFFC);
        wr_reg(8'h04, 32'hFFFF_FFFE);
        wr_reg(8'h08, 32'h3);
        idle(2);
        rd_reg(8'h04);
        rd_reg(8'h08);
        wr_reg(8'h08, 32'h3);
        idle(1);
        rd_reg(8'h08);

        $display("[TB] race on clear");
        wr_reg(8'h08, 32'h0);
        wr_reg(8'h00, 32'h100);
        wr_reg(8'h04, 32'hFFFF_FFFE);
        wr_reg(8'h08, 32'h3);
        idle(1);
        wr_reg(8'h08, 32'h3);
        rd_reg(8'h08);
        idle(1);

        $display("[TB] disable hold");
        wr_reg(8'h08, 32'h0);
        wr_reg(8'h04, 32'h10);
        rd_reg(8'h14);
        idle(50);
        rd_reg(8'h04);
        rd_reg(8'h14);

        $display("[TB] decode");
        wr_reg(8'h0C, 32'h0000_00A5);
        wr_reg(8'h14, 32'h1234_5678);
        rd_reg(8'h14);
        rd_reg(8'h20);
        applyStimulus(1'b0, 32'h0000_0010, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, BASE + 32'h0D, 1'b1, 1'b0, 32'h0);

        $display("[TB] digit register and read-during-write");
        wr_reg(8'h10, 32'hFFFF_F37F);
        rd_reg(8'h10);
        applyStimulus(1'b0, BASE + 32'h0C, 1'b1, 1'b1, 32'h0000_003C);
        rd_reg(8'h0C);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 11);
            if (sel <= 5)       a = BASE + 32'(sel * 4) + 32'($urandom_range(0, 3));
            else if (sel == 6)  a = BASE + 32'h18 + 32'($urandom_range(0, 231));
            else if (sel == 7)  a = $urandom;
            else if (sel <= 9)  a = BASE + 32'h04;
            else                a = BASE + 32'h08;
            wd = $urandom;
            if (a[7:0] == 8'h04 && $urandom_range(0, 1) == 1)
                wd = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else if (a[7:0] == 8'h08 && $urandom_range(0, 3) != 0)
                wd = 32'($urandom_range(0, 7));
            rd = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 99) == 0);
            applyStimulus(r, a, rd, wr, wd);
        end

        sb_strobe = 1'b0;
        waited = 0;
        while (sb_q.size() != 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
